charge_pump_phase_ctrl: RTL and testbench

CHARGE_PUMP_PHASE_CTRL -- requirements
Module: charge_pump_phase_ctrl

---
 rtl/charge_pump_pkg.sv | 24 ++
 rtl/cp_tick_gen.sv | 39 +++
 rtl/charge_pump_phase_ctrl.sv | 179 +++++++++++++++++
 tb/tb_charge_pump_phase_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charge_pump_pkg.sv
// Shared types and default constants for the charge-pump phase controller.
package charge_pump_pkg;

   // Controller operating states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SOFTSTART = 2'd1,
      ST_RUN       = 2'd2,
      ST_SKIP      = 2'd3
   } cp_state_t;

   // Default parameter values
   localparam int unsigned CP_NUM_PHASES   = 4;
   localparam int unsigned CP_DIV_W        = 8;
   localparam int unsigned CP_DEAD         = 1;
   localparam int unsigned CP_SS_SHIFT_MAX = 2;
   localparam int unsigned CP_SS_TICKS     = 4;

   // Internal field widths sized for the legal parameter ranges
   localparam int unsigned CP_SHIFT_W = 3;   // shift 0..4
   localparam int unsigned CP_DEAD_W  = 4;   // dead time 1..15
   localparam int unsigned CP_LVL_W   = 8;   // ticks per level 1..255

endpackage

// File: rtl/cp_tick_gen.sv
// Phase-period counter: emits one tick every ((div_lat+1) << shift) cycles while running.
module cp_tick_gen
   import charge_pump_pkg::*;
#(
   parameter int unsigned DIV_W        = CP_DIV_W,
   parameter int unsigned SS_SHIFT_MAX = CP_SS_SHIFT_MAX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_run,
   input  logic [DIV_W-1:0]      div_lat,
   input  logic [CP_SHIFT_W-1:0] shift,
   output logic                  tick
);

   localparam int unsigned CNT_W = DIV_W + SS_SHIFT_MAX;
   localparam int unsigned PER_W = CNT_W + 1;

   logic [CNT_W-1:0] r_cnt;
   logic [PER_W-1:0] w_period;
   logic [PER_W-1:0] w_last;

   // Period is one bit wider than the counter so div_lat+1 never wraps
   assign w_period = (PER_W'(div_lat) + PER_W'(1)) << shift;
   assign w_last   = w_period - PER_W'(1);
   assign tick     = i_run && (PER_W'(r_cnt) == w_last);

   // Counter holds at zero when stopped and restarts after every tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_run || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/charge_pump_phase_ctrl.sv
// Charge-pump phase sequencer with soft-start ramp and comparator-driven pulse skipping.
module charge_pump_phase_ctrl
   import charge_pump_pkg::*;
#(
   parameter int unsigned NUM_PHASES   = CP_NUM_PHASES,
   parameter int unsigned DIV_W        = CP_DIV_W,
   parameter int unsigned DEAD         = CP_DEAD,
   parameter int unsigned SS_SHIFT_MAX = CP_SS_SHIFT_MAX,
   parameter int unsigned SS_TICKS     = CP_SS_TICKS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DIV_W-1:0]      div_cfg,
   input  logic                  cmp_high,
   output logic [NUM_PHASES-1:0] phase,
   output logic                  busy,
   output logic                  in_softstart,
   output logic                  skipping
);

   localparam int unsigned IDX_W = $clog2(NUM_PHASES);

   cp_state_t                 r_state;
   cp_state_t                 w_nxt_state;
   logic [DIV_W-1:0]          r_div_lat;
   logic [DIV_W-1:0]          w_nxt_div;
   logic [CP_SHIFT_W-1:0]     r_shift;
   logic [CP_SHIFT_W-1:0]     w_nxt_shift;
   logic [CP_LVL_W-1:0]       r_lvl;
   logic [CP_LVL_W-1:0]       w_nxt_lvl;
   logic [IDX_W-1:0]          r_idx;
   logic [IDX_W-1:0]          w_nxt_idx;
   logic [IDX_W-1:0]          w_idx_inc;
   logic [CP_DEAD_W-1:0]      r_dead;
   logic [CP_DEAD_W-1:0]      w_nxt_dead;
   logic [NUM_PHASES-1:0]     r_phase;
   logic [NUM_PHASES-1:0]     w_nxt_phase;
   logic                      r_busy;
   logic                      r_in_ss;
   logic                      r_skipping;
   logic                      r_sync1;
   logic                      r_sync2;
   logic                      w_run;
   logic                      w_tick;

   assign phase        = r_phase;
   assign busy         = r_busy;
   assign in_softstart = r_in_ss;
   assign skipping     = r_skipping;

   // Period counter only runs while active; dropping en clears it on the same edge
   assign w_run = (r_state != ST_IDLE) && en;

   cp_tick_gen #(
      .DIV_W        (DIV_W),
      .SS_SHIFT_MAX (SS_SHIFT_MAX)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .i_run   (w_run),
      .div_lat (r_div_lat),
      .shift   (r_shift),
      .tick    (w_tick)
   );

   // Two-flop synchronizer for the asynchronous comparator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= cmp_high;
         r_sync2 <= r_sync1;
      end
   end

   assign w_idx_inc = (r_idx == IDX_W'(NUM_PHASES - 1)) ? '0 : r_idx + IDX_W'(1);

   // Next-state and next-output logic
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_div   = r_div_lat;
      w_nxt_shift = r_shift;
      w_nxt_lvl   = r_lvl;
      w_nxt_idx   = r_idx;
      w_nxt_dead  = (r_dead != '0) ? r_dead - CP_DEAD_W'(1) : '0;
      w_nxt_phase = '0;

      if (!en) begin
         w_nxt_state = ST_IDLE;
         w_nxt_shift = '0;
         w_nxt_lvl   = '0;
         w_nxt_idx   = '0;
         w_nxt_dead  = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_nxt_state = ST_SOFTSTART;
               w_nxt_div   = div_cfg;
               w_nxt_shift = CP_SHIFT_W'(SS_SHIFT_MAX);
               w_nxt_lvl   = '0;
               w_nxt_idx   = '0;
               w_nxt_dead  = CP_DEAD_W'(DEAD);
            end
            ST_SOFTSTART: begin
               if (w_tick) begin
                  w_nxt_idx  = w_idx_inc;
                  w_nxt_dead = CP_DEAD_W'(DEAD);
                  if (r_shift == '0) begin
                     w_nxt_state = ST_RUN;
                  end else if (r_lvl == CP_LVL_W'(SS_TICKS - 1)) begin
                     w_nxt_lvl   = '0;
                     w_nxt_shift = r_shift - CP_SHIFT_W'(1);
                     if (r_shift == CP_SHIFT_W'(1)) begin
                        w_nxt_state = ST_RUN;
                     end
                  end else begin
                     w_nxt_lvl = r_lvl + CP_LVL_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  if (r_sync2) begin
                     w_nxt_state = ST_SKIP;
                  end else begin
                     w_nxt_idx  = w_idx_inc;
                     w_nxt_dead = CP_DEAD_W'(DEAD);
                  end
               end
            end
            ST_SKIP: begin
               if (w_tick && !r_sync2) begin
                  w_nxt_state = ST_RUN;
                  w_nxt_idx   = w_idx_inc;
                  w_nxt_dead  = CP_DEAD_W'(DEAD);
               end
            end
            default: begin
               w_nxt_state = ST_IDLE;
            end
         endcase
      end

      // One-hot drive only in driving states once the dead time has expired
      if (((w_nxt_state == ST_SOFTSTART) || (w_nxt_state == ST_RUN)) && (w_nxt_dead == '0)) begin
         w_nxt_phase = NUM_PHASES'(1) << w_nxt_idx;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_div_lat  <= '0;
         r_shift    <= '0;
         r_lvl      <= '0;
         r_idx      <= '0;
         r_dead     <= '0;
         r_phase    <= '0;
         r_busy     <= 1'b0;
         r_in_ss    <= 1'b0;
         r_skipping <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_div_lat  <= w_nxt_div;
         r_shift    <= w_nxt_shift;
         r_lvl      <= w_nxt_lvl;
         r_idx      <= w_nxt_idx;
         r_dead     <= w_nxt_dead;
         r_phase    <= w_nxt_phase;
         r_busy     <= (w_nxt_state != ST_IDLE);
         r_in_ss    <= (w_nxt_state == ST_SOFTSTART);
         r_skipping <= (w_nxt_state == ST_SKIP);
      end
   end

endmodule

// File: tb/tb_charge_pump_phase_ctrl.sv
// Self-checking bench: directed timeline table, corner sequences, random vs. reference model.
module tb_charge_pump_phase_ctrl;

   localparam int unsigned NP    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEADT = 1;
   localparam int unsigned SSM   = 2;
   localparam int unsigned SST   = 4;
   localparam int          SS_TOTAL = (SSM == 0) ? 1 : int'(SSM * SST);

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [DW-1:0] div_cfg;
   logic          cmp_high;
   logic [NP-1:0] phase;
   logic          busy;
   logic          in_softstart;
   logic          skipping;

   int checks   = 0;
   int failures = 0;
   int k;

   always #5 clk = ~clk;

   charge_pump_phase_ctrl #(
      .NUM_PHASES   (NP),
      .DIV_W        (DW),
      .DEAD         (DEADT),
      .SS_SHIFT_MAX (SSM),
      .SS_TICKS     (SST)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .div_cfg      (div_cfg),
      .cmp_high     (cmp_high),
      .phase        (phase),
      .busy         (busy),
      .in_softstart (in_softstart),
      .skipping     (skipping)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({phase, busy, in_softstart, skipping});
   endfunction

   function automatic logic [31:0] pack(input logic [NP-1:0] ph, input logic b, input logic s, input logic sk);
      return 32'({ph, b, s, sk});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Directed timeline after en rises with div_cfg=3
   typedef struct {
      int            k;
      logic [NP-1:0] ph;
      logic          b;
      logic          ss;
      logic          sk;
   } vec_t;
   vec_t tbl [16];

   // Reference model: soft-start tick count, cycles since last phase step, plain arithmetic
   int   m_mode;   // 0 idle, 1 softstart, 2 run, 3 skip
   int   m_cnt;
   int   m_div;
   int   m_ticks;
   int   m_idx;
   int   m_since;
   logic m_s1;
   logic m_s2;

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_div = 0; m_ticks = 0; m_idx = 0; m_since = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
   endtask

   task automatic model_step();
      logic sync;
      int   shift_amt;
      int   eff;
      bit   tk;
      sync = m_s2;
      m_s2 = m_s1;
      m_s1 = cmp_high;
      if (!en) begin
         m_mode = 0; m_cnt = 0; m_ticks = 0; m_idx = 0; m_since = 0;
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1; m_div = int'(div_cfg); m_cnt = 0; m_ticks = 0; m_idx = 0; m_since = 0;
         return;
      end
      shift_amt = (m_mode == 1) ? int'(SSM) - m_ticks / int'(SST) : 0;
      eff       = (m_div + 1) << shift_amt;
      tk        = (m_cnt == eff - 1);
      m_cnt     = tk ? 0 : m_cnt + 1;
      if (m_since < 1000) m_since++;
      if (tk) begin
         case (m_mode)
            1: begin
               m_ticks++;
               m_idx   = (m_idx + 1) % int'(NP);
               m_since = 0;
               if (m_ticks >= SS_TOTAL) m_mode = 2;
            end
            2: begin
               if (sync) m_mode = 3;
               else begin m_idx = (m_idx + 1) % int'(NP); m_since = 0; end
            end
            3: begin
               if (!sync) begin m_mode = 2; m_idx = (m_idx + 1) % int'(NP); m_since = 0; end
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] model_outs();
      logic [NP-1:0] ph;
      ph = '0;
      if ((m_mode == 1 || m_mode == 2) && m_since >= int'(DEADT)) ph = NP'(1) << m_idx;
      return pack(ph, m_mode != 0, m_mode == 1, m_mode == 3);
   endfunction

   initial begin
      logic [NP-1:0] last_ph;
      bit            seen;

      tbl[0]  = '{0,   4'b0000, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1,   4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{15,  4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{16,  4'b0000, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{17,  4'b0010, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{33,  4'b0100, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{49,  4'b1000, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{64,  4'b0000, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{65,  4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{73,  4'b0010, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{95,  4'b1000, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{96,  4'b0000, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{97,  4'b0001, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{100, 4'b0000, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{101, 4'b0010, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{105, 4'b0100, 1'b1, 1'b0, 1'b0};

      // Reset state
      rst = 1'b1; en = 1'b0; cmp_high = 1'b0; div_cfg = DW'(3);
      #1;
      check("reset_outs", outs(), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_en0", outs(), 32'h0);

      // Soft-start and run timeline
      @(negedge clk); en = 1'b1;
      k = -1;
      step();
      for (int i = 0; i < 16; i++) begin
         while (k < tbl[i].k) step();
         check($sformatf("timeline_k%0d", tbl[i].k), outs(),
               pack(tbl[i].ph, tbl[i].b, tbl[i].ss, tbl[i].sk));
      end

      // Asynchronous reset mid-run, sampled before the next edge
      #2 rst = 1'b1;
      #1;
      check("async_rst", outs(), 32'h0);
      @(negedge clk); rst = 1'b0; en = 1'b0;
      @(negedge clk);

      // en dropped on a soft-start tick, then full restart
      en = 1'b1;
      k = -1;
      step();
      while (k < 15) step();
      check("ss_pre_drop", outs(), pack(4'b0001, 1'b1, 1'b1, 1'b0));
      @(negedge clk); en = 1'b0;
      step();
      check("drop_on_tick", outs(), 32'h0);
      @(negedge clk); en = 1'b1;
      k = -1;
      step();
      while (k < 15) step();
      check("restart_k15", outs(), pack(4'b0001, 1'b1, 1'b1, 1'b0));
      step();
      check("restart_k16", outs(), pack(4'b0000, 1'b1, 1'b1, 1'b0));
      step();
      check("restart_k17", outs(), pack(4'b0010, 1'b1, 1'b1, 1'b0));

      // Pulse skipping in run
      while (k < 97) step();
      check("run_k97", outs(), pack(4'b0001, 1'b1, 1'b0, 1'b0));
      last_ph = phase;
      @(negedge clk); cmp_high = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         step();
         if (skipping) seen = 1'b1;
         else if (phase != '0) last_ph = phase;
      end
      check("skip_seen", 32'(seen), 32'h1);
      check("skip_time", 32'(k), 32'd100);
      check("skip_outs", outs(), pack(4'b0000, 1'b1, 1'b0, 1'b1));
      while (k < 103) step();
      check("skip_hold", outs(), pack(4'b0000, 1'b1, 1'b0, 1'b1));
      @(negedge clk); cmp_high = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         step();
         if (!skipping) seen = 1'b1;
      end
      check("unskip_seen", 32'(seen), 32'h1);
      check("unskip_time", 32'(k), 32'd108);
      check("unskip_dead", outs(), pack(4'b0000, 1'b1, 1'b0, 1'b0));
      step();
      check("unskip_next_idx", 32'(phase), 32'({last_ph[NP-2:0], last_ph[NP-1]}));

      // div_cfg=0: run period equals dead time so phases stay low; later div_cfg changes ignored
      @(negedge clk); en = 1'b0;
      @(negedge clk); div_cfg = '0; en = 1'b1;
      k = -1;
      step();
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         step();
         if (!in_softstart) seen = 1'b1;
      end
      check("div0_reach_run", 32'(seen), 32'h1);
      check("div0_ss_len", 32'(k), 32'd24);
      for (int c = 0; c < 6; c++) begin
         step();
         check("div0_run_low", outs(), pack(4'b0000, 1'b1, 1'b0, 1'b0));
      end
      @(negedge clk); div_cfg = DW'(7);
      for (int c = 0; c < 6; c++) begin
         step();
         check("div_change_ignored", outs(), pack(4'b0000, 1'b1, 1'b0, 1'b0));
      end

      // Randomized run against the reference model
      @(negedge clk); rst = 1'b1; en = 1'b0; cmp_high = 1'b0;
      @(negedge clk); rst = 1'b0;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (en) en = ($urandom_range(0, 249) != 0);
         else    en = ($urandom_range(0, 3) == 0);
         div_cfg = DW'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) cmp_high = ~cmp_high;
         @(posedge clk);
         model_step();
         #1;
         check("random_vs_model", outs(), model_outs());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Any two phase bits high together is an error
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($countones(phase) > 1) begin
            failures++;
            $display("FAIL overlap got=%0h exp=onehot_or_zero", phase);
         end
      end
   end

endmodule
